// File: rtl/rob_queue.sv
// Circular reorder buffer: in-order alloc at tail, tagged writeback, in-order commit at head.
// Optional macro ROB_WB_FORWARD_EN forwards a same-cycle writeback onto the query port.
`timescale 1ns/1ps
module rob_queue #(
  parameter int BUF_SIZE_LOG = 4,
  parameter int DATA_W       = 32,
  parameter int TAG_W        = BUF_SIZE_LOG + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_valid,
  input  logic [4:0]              alloc_dest,
  input  logic [DATA_W-1:0]       alloc_pc,
  output logic                    alloc_ready,
  output logic [TAG_W-1:0]        alloc_tag,
  input  logic                    wb_valid,
  input  logic [TAG_W-1:0]        wb_tag,
  input  logic [DATA_W-1:0]       wb_result,
  input  logic [TAG_W-1:0]        query_tag,
  output logic                    query_hit,
  output logic [DATA_W-1:0]       query_value,
  output logic                    commit_valid,
  output logic [4:0]              commit_dest,
  output logic [DATA_W-1:0]       commit_pc,
  output logic [DATA_W-1:0]       commit_result,
  input  logic                    commit_ready,
  input  logic                    flush,
  output logic [BUF_SIZE_LOG:0]   count
);

  localparam int unsigned DEPTH = 2 ** BUF_SIZE_LOG;
  localparam int          CW    = BUF_SIZE_LOG + 1;

  typedef enum logic [1:0] {
    S_NOT_USED,
    S_NOT_EXECUTED,
    S_EXECUTED
  } slot_state_e;

  typedef logic [BUF_SIZE_LOG-1:0] idx_t;
  typedef logic [TAG_W-1:0]        tag_t;

  slot_state_e       state_q  [DEPTH];
  slot_state_e       state_d  [DEPTH];
  logic [4:0]        dest_q   [DEPTH];
  logic [4:0]        dest_d   [DEPTH];
  logic [DATA_W-1:0] pc_q     [DEPTH];
  logic [DATA_W-1:0] pc_d     [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];
  logic [DATA_W-1:0] result_d [DEPTH];
  tag_t              head_q, head_d, tail_q, tail_d;

  // A tag is live when its distance from head is below the occupancy (modular).
  function automatic logic in_window(input tag_t t, input tag_t h, input tag_t tl);
    tag_t off;
    tag_t occ;
    off = t - h;
    occ = tl - h;
    return off < occ;
  endfunction

  idx_t head_idx, tail_idx, wb_idx, query_idx;
  logic full, empty, head_used, wb_accept, alloc_fire, commit_fire;

  assign head_idx  = head_q[BUF_SIZE_LOG-1:0];
  assign tail_idx  = tail_q[BUF_SIZE_LOG-1:0];
  assign wb_idx    = wb_tag[BUF_SIZE_LOG-1:0];
  assign query_idx = query_tag[BUF_SIZE_LOG-1:0];

  assign empty     = (head_q == tail_q);
  assign full      = (head_idx == tail_idx) && (head_q[TAG_W-1] != tail_q[TAG_W-1]);
  assign head_used = (state_q[head_idx] != S_NOT_USED);
  assign wb_accept = wb_valid && in_window(wb_tag, head_q, tail_q)
                     && (state_q[wb_idx] == S_NOT_EXECUTED);

  assign alloc_ready   = !full;
  assign alloc_tag     = tail_q;
  assign count         = CW'(tail_q - head_q);
  assign commit_valid  = !empty && (state_q[head_idx] == S_EXECUTED);
  assign commit_dest   = head_used ? dest_q[head_idx]   : '0;
  assign commit_pc     = head_used ? pc_q[head_idx]     : '0;
  assign commit_result = head_used ? result_q[head_idx] : '0;

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = commit_valid && commit_ready;

  always_comb begin
    query_hit   = 1'b0;
    query_value = '0;
    if (in_window(query_tag, head_q, tail_q) && (state_q[query_idx] == S_EXECUTED)) begin
      query_hit   = 1'b1;
      query_value = result_q[query_idx];
    end
`ifdef ROB_WB_FORWARD_EN
    if (wb_accept && (wb_tag == query_tag)) begin
      query_hit   = 1'b1;
      query_value = wb_result;
    end
`endif
  end

  // Commit, writeback and alloc touch disjoint slots unless flushed, so order is free.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    state_d  = state_q;
    dest_d   = dest_q;
    pc_d     = pc_q;
    result_d = result_q;
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_d[idx_t'(i)] = S_NOT_USED;
      end
      tail_d = head_q;
    end else begin
      if (commit_fire) begin
        state_d[head_idx] = S_NOT_USED;
        head_d            = head_q + TAG_W'(1);
      end
      if (wb_accept) begin
        state_d[wb_idx]  = S_EXECUTED;
        result_d[wb_idx] = wb_result;
      end
      if (alloc_fire) begin
        state_d[tail_idx]  = S_NOT_EXECUTED;
        dest_d[tail_idx]   = alloc_dest;
        pc_d[tail_idx]     = alloc_pc;
        result_d[tail_idx] = '0;
        tail_d             = tail_q + TAG_W'(1);
      end
    end
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_q[idx_t'(i)]  <= S_NOT_USED;
        dest_q[idx_t'(i)]   <= '0;
        pc_q[idx_t'(i)]     <= '0;
        result_q[idx_t'(i)] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      state_q  <= state_d;
      dest_q   <= dest_d;
      pc_q     <= pc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue: commits are checked by a monitor against a queue of expected entries.
`timescale 1ns/1ps
module tb_rob_queue;

  logic        clk = 1'b1;
  logic        reset;
  logic        alloc_valid;
  logic [4:0]  alloc_dest;
  logic [31:0] alloc_pc;
  logic        alloc_ready;
  logic [4:0]  alloc_tag;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [31:0] wb_result;
  logic [4:0]  query_tag;
  logic        query_hit;
  logic [31:0] query_value;
  logic        commit_valid;
  logic [4:0]  commit_dest;
  logic [31:0] commit_pc;
  logic [31:0] commit_result;
  logic        commit_ready;
  logic        flush;
  logic [4:0]  count;

  rob_queue #(.BUF_SIZE_LOG(4), .DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_result(wb_result),
    .query_tag(query_tag), .query_hit(query_hit), .query_value(query_value),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_pc(commit_pc),
    .commit_result(commit_result), .commit_ready(commit_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // State changes on negedge; sample two units after the posedge.
  always @(posedge clk) begin
    #2;
    if (reset === 1'b1 && flush === 1'b0 && commit_valid === 1'b1 && commit_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got pc 0x%0h required none", commit_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_dest", 32'(commit_dest), 32'(e.dest));
        chk("commit_pc", commit_pc, e.pc);
        chk("commit_result", commit_result, e.res);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; alloc_valid = 1'b0; alloc_dest = '0; alloc_pc = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_result = '0; query_tag = '0;
    commit_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);

    reset = 1'b1;
    #1;
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_alloc_tag", 32'(alloc_tag), 0);
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_query_hit", 32'(query_hit), 0);
    chk("rst_query_value", query_value, 0);
    chk("rst_count", 32'(count), 0);
    @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i + 1);
      alloc_pc    = 32'h100 + 32'(4 * i);
      #1;
      chk("fill_alloc_tag", 32'(alloc_tag), 32'(i));
      chk("fill_alloc_ready", 32'(alloc_ready), 1);
      chk("fill_count", 32'(count), 32'(i));
      @(posedge clk);
    end

    alloc_dest = 5'd31; alloc_pc = 32'hFFF;
    #1;
    chk("full_alloc_ready", 32'(alloc_ready), 0);
    chk("full_count", 32'(count), 16);
    chk("full_alloc_tag", 32'(alloc_tag), 16);
    @(posedge clk);

    alloc_valid = 1'b0; commit_ready = 1'b1;
    wb_valid = 1'b1; wb_tag = 5'd2; wb_result = 32'hA;
    #1;
    chk("overflow_ignored_count", 32'(count), 16);
    chk("overflow_alloc_tag", 32'(alloc_tag), 16);
    chk("wb2_commit_valid", 32'(commit_valid), 0);
    @(posedge clk);

    wb_tag = 5'd1; wb_result = 32'hB;
    #1;
    chk("wb1_commit_valid", 32'(commit_valid), 0);
    @(posedge clk);

    wb_tag = 5'd0; wb_result = 32'hC;
    #1;
    chk("wb_head_same_cycle", 32'(commit_valid), 0);
    exp_q.push_back('{dest: 5'd1, pc: 32'h100, res: 32'hC});
    exp_q.push_back('{dest: 5'd2, pc: 32'h104, res: 32'hB});
    exp_q.push_back('{dest: 5'd3, pc: 32'h108, res: 32'hA});
    @(posedge clk);

    wb_valid = 1'b0;
    alloc_valid = 1'b1; alloc_dest = 5'd20; alloc_pc = 32'h200;
    #1;
    chk("full_commit_valid", 32'(commit_valid), 1);
    chk("full_commit_alloc_ready", 32'(alloc_ready), 0);
    chk("full_commit_count", 32'(count), 16);
    @(posedge clk);

    #1;
    chk("wrap_alloc_ready", 32'(alloc_ready), 1);
    chk("wrap_alloc_tag", 32'(alloc_tag), 16);
    chk("wrap_count", 32'(count), 15);
    @(posedge clk);

    alloc_valid = 1'b0;
    #1;
    chk("alloc_commit_count", 32'(count), 15);
    chk("post_wrap_alloc_tag", 32'(alloc_tag), 17);
    @(posedge clk);

    #1;
    chk("head_stall_commit_valid", 32'(commit_valid), 0);
    chk("head_stall_count", 32'(count), 14);
    chk("head_stall_commit_pc", commit_pc, 32'h10C);
    @(posedge clk);

    wb_valid = 1'b1; wb_tag = 5'd0; wb_result = 32'hDEAD; query_tag = 5'd16;
    #1;
    chk("stale_wb_query_hit", 32'(query_hit), 0);
    @(posedge clk);

    wb_valid = 1'b0;
    #1;
    chk("stale_after_query_hit", 32'(query_hit), 0);
    chk("stale_after_query_value", query_value, 0);
    @(posedge clk);

    wb_valid = 1'b1; wb_tag = 5'd5; wb_result = 32'h55; query_tag = 5'd5;
    #1;
`ifdef ROB_WB_FORWARD_EN
    chk("fwd_query_hit", 32'(query_hit), 1);
    chk("fwd_query_value", query_value, 32'h55);
`else
    chk("nofwd_query_hit", 32'(query_hit), 0);
    chk("nofwd_query_value", query_value, 0);
`endif
    @(posedge clk);

    wb_valid = 1'b0;
    #1;
    chk("query_hit_next", 32'(query_hit), 1);
    chk("query_value_next", query_value, 32'h55);
    chk("wb5_commit_valid", 32'(commit_valid), 0);
    @(posedge clk);

    wb_valid = 1'b1; wb_tag = 5'd5; wb_result = 32'h66;
    #1;
    chk("dup_wb_query_value", query_value, 32'h55);
    @(posedge clk);

    wb_valid = 1'b0;
    #1;
    chk("dup_wb_after_value", query_value, 32'h55);
    @(posedge clk);

    flush = 1'b1;
    alloc_valid = 1'b1; alloc_dest = 5'd9; alloc_pc = 32'h300;
    wb_valid = 1'b1; wb_tag = 5'd4; wb_result = 32'h44;
    @(posedge clk);

    flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
    #1;
    chk("flush_count", 32'(count), 0);
    chk("flush_commit_valid", 32'(commit_valid), 0);
    chk("flush_alloc_tag", 32'(alloc_tag), 3);
    chk("flush_alloc_ready", 32'(alloc_ready), 1);
    chk("flush_query_hit", 32'(query_hit), 0);
    chk("flush_commit_pc", commit_pc, 0);
    chk("flush_commit_dest", 32'(commit_dest), 0);
    @(posedge clk);

    alloc_valid = 1'b1; alloc_dest = 5'd10; alloc_pc = 32'h400;
    #1;
    chk("post_flush_alloc_tag", 32'(alloc_tag), 3);
    @(posedge clk);

    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = 5'd3; wb_result = 32'h77;
    #1;
    chk("post_flush_count", 32'(count), 1);
    exp_q.push_back('{dest: 5'd10, pc: 32'h400, res: 32'h77});
    @(posedge clk);

    wb_valid = 1'b0;
    #1;
    chk("post_flush_commit_valid", 32'(commit_valid), 1);
    @(posedge clk);

    #1;
    chk("drained_count", 32'(count), 0);
    chk("drained_alloc_tag", 32'(alloc_tag), 4);
    chk("drained_commit_valid", 32'(commit_valid), 0);
    @(posedge clk);

    commit_ready = 1'b0;
    alloc_valid = 1'b1; alloc_dest = 5'd11; alloc_pc = 32'h500;
    #1;
    chk("pre_reset_alloc_tag", 32'(alloc_tag), 4);
    @(posedge clk);

    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = 5'd4; wb_result = 32'h88;
    @(posedge clk);

    wb_valid = 1'b0; reset = 1'b0;
    #1;
    chk("pre_reset_commit_valid", 32'(commit_valid), 1);
    chk("pre_reset_commit_result", commit_result, 32'h88);
    @(posedge clk);

    reset = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_alloc_tag", 32'(alloc_tag), 0);
    chk("midrst_commit_valid", 32'(commit_valid), 0);
    chk("midrst_commit_result", commit_result, 0);
    @(posedge clk);
    @(posedge clk);

    chk("pending_commits", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
